// File: rtl/mdu_seq_pkg.sv
// Shared opcode encoding, sequencer state codes and the start-decode helper
// for the multiply/divide unit.
package mdu_seq_pkg;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DIV  = 2'd2
  } mdu_state_e;

  function automatic logic is_start(input logic [3:0] op);
    return (op >= OP_MULT) && (op <= OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_seq_if.sv
// EX-stage <-> MDU signal bundle. The EX side (master) drives opcode and operands;
// the MDU (slave) returns start/busy, read data, HI/LO and its FSM state for debug.
// Handshake: no ready path -- start_o is asserted for any op 1..4 in the same cycle,
// and while busy_o is high the stall unit must hold off new start and mthi/mtlo ops.
interface mdu_seq_if;
  import mdu_seq_pkg::*;

  logic [3:0]  op_i;
  logic [31:0] rs_i;
  logic [31:0] rt_i;
  logic        start_o;
  logic        busy_o;
  logic [31:0] rdata_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  mdu_state_e  state_o;

  modport master (
    output op_i, rs_i, rt_i,
    input  start_o, busy_o, rdata_o, hi_o, lo_o, state_o
  );

  modport slave (
    input  op_i, rs_i, rt_i,
    output start_o, busy_o, rdata_o, hi_o, lo_o, state_o
  );

endinterface

// File: rtl/mdu_arith.sv
// Combinational 64-bit product, quotient and remainder of the latched operands.
// The quotient/remainder are forced to zero on a zero divisor so no X ever escapes.
module mdu_arith (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        is_signed,
  output logic [63:0] prod,
  output logic [31:0] quot,
  output logic [31:0] rem,
  output logic        div_zero
);

  logic [63:0] a_ext;
  logic [63:0] b_ext;

  always_comb begin
    a_ext    = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
    b_ext    = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
    prod     = a_ext * b_ext;
    div_zero = (b == 32'd0);
    quot     = 32'd0;
    rem      = 32'd0;
    if (!div_zero) begin
      // SV signed / and % truncate toward zero; remainder follows the dividend
      if (is_signed) begin
        quot = $signed(a) / $signed(b);
        rem  = $signed(a) % $signed(b);
      end else begin
        quot = a / b;
        rem  = a % b;
      end
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide sequencer: latches operands on start, counts the fixed
// latency, owns HI/LO and serves mfhi/mflo reads to the EX result mux.
module mdu_seq
  import mdu_seq_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic         clk,
  input  logic         reset,
  mdu_seq_if.slave     bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic              busy;
  logic [31:0]       hi;
  logic [31:0]       lo;
  logic [31:0]       op_a;
  logic [31:0]       op_b;
  logic              op_signed;

  logic [63:0]       prod;
  logic [31:0]       quot;
  logic [31:0]       rem;
  logic              div_zero;

  mdu_arith u_arith (
    .a         (op_a),
    .b         (op_b),
    .is_signed (op_signed),
    .prod      (prod),
    .quot      (quot),
    .rem       (rem),
    .div_zero  (div_zero)
  );

  always_comb begin
    bus.start_o = is_start(bus.op_i);
    bus.rdata_o = 32'd0;
    if (bus.op_i == OP_MFHI)      bus.rdata_o = hi;
    else if (bus.op_i == OP_MFLO) bus.rdata_o = lo;
  end

  assign bus.busy_o  = busy;
  assign bus.hi_o    = hi;
  assign bus.lo_o    = lo;
  assign bus.state_o = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      hi        <= 32'd0;
      lo        <= 32'd0;
      op_a      <= 32'd0;
      op_b      <= 32'd0;
      op_signed <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.op_i == OP_MULT || bus.op_i == OP_MULTU) begin
            state     <= ST_MULT;
            cnt       <= CNT_W'(MULT_CYCLES - 1);
            busy      <= 1'b1;
            op_a      <= bus.rs_i;
            op_b      <= bus.rt_i;
            op_signed <= (bus.op_i == OP_MULT);
          end else if (bus.op_i == OP_DIV || bus.op_i == OP_DIVU) begin
            state     <= ST_DIV;
            cnt       <= CNT_W'(DIV_CYCLES - 1);
            busy      <= 1'b1;
            op_a      <= bus.rs_i;
            op_b      <= bus.rt_i;
            op_signed <= (bus.op_i == OP_DIV);
          end else if (bus.op_i == OP_MTHI) begin
            hi <= bus.rs_i;
          end else if (bus.op_i == OP_MTLO) begin
            lo <= bus.rs_i;
          end
        end
        ST_MULT: begin
          if (cnt == '0) begin
            {hi, lo} <= prod;
            state    <= ST_IDLE;
            busy     <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_DIV: begin
          if (cnt == '0) begin
            // a zero divisor burns the full latency but leaves HI/LO untouched
            if (!div_zero) begin
              hi <= rem;
              lo <= quot;
            end
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed self-checking bench for mdu_seq: latency, arithmetic, HI/LO moves,
// divide-by-zero, mid-operation reset and ops issued while busy.
module tb_mdu_seq;
  import mdu_seq_pkg::*;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  mdu_seq_if bus ();

  mdu_seq #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: present one op for exactly one rising edge, then return to none
  task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
    @(negedge clk);
    bus.op_i = op;
    bus.rs_i = rs;
    bus.rt_i = rt;
    @(posedge clk);
    #1;
    bus.op_i = OP_NONE;
  endtask

  // counts negedges with busy_o high; ends on the first negedge with busy_o low
  task automatic wait_busy(output int n);
    n = 0;
    while (n < 64) begin
      @(negedge clk);
      if (!bus.busy_o) break;
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %0b want 0", bus.busy_o); end
    n_cmp++; if (bus.hi_o !== 32'd0) begin n_bad++; $display("FAIL rst_hi got %h want 0", bus.hi_o); end
    n_cmp++; if (bus.lo_o !== 32'd0) begin n_bad++; $display("FAIL rst_lo got %h want 0", bus.lo_o); end
    n_cmp++; if (bus.state_o !== ST_IDLE) begin n_bad++; $display("FAIL rst_state got %0d want 0", bus.state_o); end
    bus.op_i = OP_DIVU;
    #1;
    n_cmp++; if (bus.start_o !== 1'b1) begin n_bad++; $display("FAIL rst_start got %0b want 1", bus.start_o); end
    bus.op_i = 4'd12;
    #1;
    n_cmp++; if (bus.start_o !== 1'b0) begin n_bad++; $display("FAIL rst_start_rsvd got %0b want 0", bus.start_o); end
    bus.op_i = OP_MFLO;
    #1;
    n_cmp++; if (bus.rdata_o !== 32'd0) begin n_bad++; $display("FAIL rst_rdata got %h want 0", bus.rdata_o); end
    bus.op_i = OP_NONE;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_mult();
    int n;
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    bus.rs_i = 32'h1357_9BDF;   // operand bus changes after start must not matter
    bus.rt_i = 32'h2468_ACE0;
    wait_busy(n);
    n_cmp++; if (n !== 5) begin n_bad++; $display("FAIL mult_busy got %0d want 5", n); end
    n_cmp++; if (bus.hi_o !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mult_hi got %h want ffffffff", bus.hi_o); end
    n_cmp++; if (bus.lo_o !== 32'hFFFF_FFEB) begin n_bad++; $display("FAIL mult_lo got %h want ffffffeb", bus.lo_o); end
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    wait_busy(n);
    n_cmp++; if (bus.hi_o !== 32'd1) begin n_bad++; $display("FAIL multu_hi got %h want 1", bus.hi_o); end
    n_cmp++; if (bus.lo_o !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL multu_lo got %h want fffffffe", bus.lo_o); end
  endtask

  task automatic test_div();
    int n;
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_busy(n);
    n_cmp++; if (n !== 10) begin n_bad++; $display("FAIL divu_busy got %0d want 10", n); end
    n_cmp++; if (bus.lo_o !== 32'd14) begin n_bad++; $display("FAIL divu_lo got %h want e", bus.lo_o); end
    n_cmp++; if (bus.hi_o !== 32'd2) begin n_bad++; $display("FAIL divu_hi got %h want 2", bus.hi_o); end
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_busy(n);
    n_cmp++; if (bus.lo_o !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL div_lo got %h want fffffffd", bus.lo_o); end
    n_cmp++; if (bus.hi_o !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL div_hi got %h want ffffffff", bus.hi_o); end
  endtask

  task automatic test_move();
    issue(OP_MTHI, 32'h0000_1234, 32'd0);
    @(negedge clk);
    bus.op_i = OP_MFHI;
    #1;
    n_cmp++; if (bus.rdata_o !== 32'h0000_1234) begin n_bad++; $display("FAIL mfhi got %h want 1234", bus.rdata_o); end
    bus.op_i = OP_NONE;
    issue(OP_MTLO, 32'hCAFE_0042, 32'd0);
    @(negedge clk);
    bus.op_i = OP_MFLO;
    #1;
    n_cmp++; if (bus.rdata_o !== 32'hCAFE_0042) begin n_bad++; $display("FAIL mflo got %h want cafe0042", bus.rdata_o); end
    n_cmp++; if (bus.hi_o !== 32'h0000_1234) begin n_bad++; $display("FAIL mtlo_keeps_hi got %h want 1234", bus.hi_o); end
    bus.op_i = OP_NONE;
  endtask

  task automatic test_div_zero();
    int n;
    issue(OP_MTHI, 32'h0000_00AA, 32'd0);
    issue(OP_MTLO, 32'h0000_00BB, 32'd0);
    issue(OP_DIV, 32'd5, 32'd0);
    wait_busy(n);
    n_cmp++; if (n !== 10) begin n_bad++; $display("FAIL dz_busy got %0d want 10", n); end
    n_cmp++; if (bus.hi_o !== 32'h0000_00AA) begin n_bad++; $display("FAIL dz_hi got %h want aa", bus.hi_o); end
    n_cmp++; if (bus.lo_o !== 32'h0000_00BB) begin n_bad++; $display("FAIL dz_lo got %h want bb", bus.lo_o); end
  endtask

  task automatic test_reset_mid();
    int n;
    issue(OP_MTHI, 32'h0000_0077, 32'd0);
    issue(OP_DIVU, 32'd1000, 32'd3);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL rmid_busy got %0b want 0", bus.busy_o); end
    n_cmp++; if (bus.hi_o !== 32'd0) begin n_bad++; $display("FAIL rmid_hi got %h want 0", bus.hi_o); end
    n_cmp++; if (bus.lo_o !== 32'd0) begin n_bad++; $display("FAIL rmid_lo got %h want 0", bus.lo_o); end
    issue(OP_MULT, 32'd6, 32'd7);
    wait_busy(n);
    n_cmp++; if (n !== 5) begin n_bad++; $display("FAIL rmid_mult_busy got %0d want 5", n); end
    n_cmp++; if (bus.lo_o !== 32'd42) begin n_bad++; $display("FAIL rmid_mult_lo got %h want 2a", bus.lo_o); end
  endtask

  task automatic test_busy_ignore();
    int n;
    int rest;
    issue(OP_MTHI, 32'h0000_0055, 32'd0);
    issue(OP_MULT, 32'd3, 32'd4);
    n = 0;
    @(negedge clk);
    if (bus.busy_o) n++;
    bus.op_i = OP_DIV; bus.rs_i = 32'd100; bus.rt_i = 32'd5;
    @(negedge clk);
    if (bus.busy_o) n++;
    bus.op_i = OP_MFHI;
    #1;
    n_cmp++; if (bus.rdata_o !== 32'h0000_0055) begin n_bad++; $display("FAIL busy_mfhi got %h want 55", bus.rdata_o); end
    @(negedge clk);
    if (bus.busy_o) n++;
    bus.op_i = OP_MTLO; bus.rs_i = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.op_i = OP_NONE;
    if (bus.busy_o) begin
      n++;
      wait_busy(rest);
      n = n + rest;
    end
    n_cmp++; if (n !== 5) begin n_bad++; $display("FAIL busy_ign_len got %0d want 5", n); end
    n_cmp++; if (bus.hi_o !== 32'd0) begin n_bad++; $display("FAIL busy_ign_hi got %h want 0", bus.hi_o); end
    n_cmp++; if (bus.lo_o !== 32'd12) begin n_bad++; $display("FAIL busy_ign_lo got %h want c", bus.lo_o); end
  endtask

  task automatic test_back_to_back();
    int n;
    issue(OP_MULTU, 32'd9, 32'd9);
    wait_busy(n);
    // first idle cycle: start the next op immediately
    bus.op_i = OP_DIVU; bus.rs_i = 32'd81; bus.rt_i = 32'd4;
    @(posedge clk);
    #1;
    bus.op_i = OP_NONE;
    @(negedge clk);
    n_cmp++; if (bus.busy_o !== 1'b1) begin n_bad++; $display("FAIL b2b_busy got %0b want 1", bus.busy_o); end
    n_cmp++; if (bus.lo_o !== 32'd81) begin n_bad++; $display("FAIL b2b_mult_lo got %h want 51", bus.lo_o); end
    wait_busy(n);
    n_cmp++; if (n !== 9) begin n_bad++; $display("FAIL b2b_div_busy got %0d want 9", n); end
    n_cmp++; if (bus.lo_o !== 32'd20) begin n_bad++; $display("FAIL b2b_div_lo got %h want 14", bus.lo_o); end
    n_cmp++; if (bus.hi_o !== 32'd1) begin n_bad++; $display("FAIL b2b_div_hi got %h want 1", bus.hi_o); end
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    bus.op_i = OP_NONE;
    bus.rs_i = 32'd0;
    bus.rt_i = 32'd0;
    test_reset();
    test_mult();
    test_div();
    test_move();
    test_div_zero();
    test_reset_mid();
    test_busy_ignore();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
